// File: rtl/vga_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// vga_cfg_arbiter
//
// Round-robin arbiter and sequencer in front of the VGA_Control configuration
// port. Several configuration masters (mode-select logic, debug bridge,
// power-on loader) post writes on Req. One at a time, a write is granted,
// checked, and issued as a single-cycle C_valid strobe. Writes to the
// resolution-select register then wait for the C_rdy load acknowledge. Each
// requester sees a one-cycle Ack on success, or a one-cycle Err on an illegal
// mode code or a missing acknowledge.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous active-high reset
//   Req       in   [NUM_REQ]    per-requester request, held until Ack/Err
//   Req_addr  in   [NUM_REQ*CW] requester i address at [i*CW +: CW]
//   Req_data  in   [NUM_REQ*CW] requester i data, same slicing
//   Ack       out  [NUM_REQ]    one-hot success pulse
//   Err       out  [NUM_REQ]    one-hot failure pulse
//   C_valid   out  config write strobe
//   C_addr    out  [CW] config address, holds between strobes
//   C_data    out  [CW] config data, holds between strobes
//   C_rdy     in   load acknowledge, honoured only while waiting for it
//   Busy      out  high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module vga_cfg_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int CONFIG_WIDTH    = 8,
  parameter int ADDR_VGA_CONFIG = 0,
  parameter int MODE_MAX        = 2,
  parameter int TIMEOUT         = 15
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [NUM_REQ-1:0]               Req,
  input  logic [NUM_REQ*CONFIG_WIDTH-1:0]  Req_addr,
  input  logic [NUM_REQ*CONFIG_WIDTH-1:0]  Req_data,
  output logic [NUM_REQ-1:0]               Ack,
  output logic [NUM_REQ-1:0]               Err,
  output logic                             C_valid,
  output logic [CONFIG_WIDTH-1:0]          C_addr,
  output logic [CONFIG_WIDTH-1:0]          C_data,
  input  logic                             C_rdy,
  output logic                             Busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CONFIG_WIDTH-1:0] VGA_ADDR   = CONFIG_WIDTH'(ADDR_VGA_CONFIG);
  localparam logic [CONFIG_WIDTH-1:0] MODE_MAX_C = CONFIG_WIDTH'(MODE_MAX);
  // Last WAIT cycle: the counter is about to reach TIMEOUT.
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        g_q, g_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [CONFIG_WIDTH-1:0] c_addr_q, c_addr_d;
  logic [CONFIG_WIDTH-1:0] c_data_q, c_data_d;

  // Round-robin pick: first set Req bit scanning ptr, ptr+1, ... mod NUM_REQ.
  logic                    any_req;
  logic [IDX_W-1:0]        grant_idx;
  logic [CONFIG_WIDTH-1:0] sel_addr;
  logic [CONFIG_WIDTH-1:0] sel_data;

  always_comb begin : rr_pick
    int cand;
    // NOTE: every variable written in a combinational block gets a default
    // before any branch; a path that skips an assignment would infer a latch.
    any_req   = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_req && Req[IDX_W'(cand)]) begin
        any_req   = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign sel_addr = Req_addr[grant_idx*CONFIG_WIDTH +: CONFIG_WIDTH];
  assign sel_data = Req_data[grant_idx*CONFIG_WIDTH +: CONFIG_WIDTH];

  // State register
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (Rst) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          g_d = grant_idx;
          if (sel_addr == VGA_ADDR && sel_data > MODE_MAX_C) begin
            // Illegal mode: reject without touching the config bus, so
            // C_addr/C_data keep showing the last issued write.
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            // The output registers double as the latched request, so the
            // bus carries the values from the first ISSUE cycle onward.
            err_d    = 1'b0;
            c_addr_d = sel_addr;
            c_data_d = sel_data;
            state_d  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (c_addr_q == VGA_ADDR) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          // Other registers are not acknowledged by VGA_Control.
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end

      S_WAIT: begin
        // C_rdy is tested first so a late acknowledge on the final cycle
        // still counts as success.
        if (C_rdy) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        ptr_d   = (g_q == IDX_LAST) ? '0 : g_q + 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from registered state only, so a reset clears them
  // from the cycle after Rst is sampled.
  always_comb begin
    C_valid = (state_q == S_ISSUE);
    Busy    = (state_q != S_IDLE);
    C_addr  = c_addr_q;
    C_data  = c_data_q;
    Ack     = '0;
    Err     = '0;
    if (state_q == S_RESP) begin
      if (err_q) Err[g_q] = 1'b1;
      else       Ack[g_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_cfg_arbiter
//
// Directed bench for vga_cfg_arbiter with three requesters and TIMEOUT=4.
// Inputs change 1 ns after a rising edge and outputs are checked at that same
// point, so "cycle N" is the clock period following the Nth edge after the
// request was first presented in IDLE.
// ---------------------------------------------------------------------------
module tb_vga_cfg_arbiter;

  localparam int NR = 3;
  localparam int CW = 8;
  localparam int TO = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NR-1:0]    Req;
  logic [NR*CW-1:0] Req_addr;
  logic [NR*CW-1:0] Req_data;
  logic [NR-1:0]    Ack;
  logic [NR-1:0]    Err;
  logic             C_valid;
  logic [CW-1:0]    C_addr;
  logic [CW-1:0]    C_data;
  logic             C_rdy;
  logic             Busy;

  int tests  = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  vga_cfg_arbiter #(
    .NUM_REQ        (NR),
    .CONFIG_WIDTH   (CW),
    .ADDR_VGA_CONFIG(0),
    .MODE_MAX       (2),
    .TIMEOUT        (TO)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Req     (Req),
    .Req_addr(Req_addr),
    .Req_data(Req_data),
    .Ack     (Ack),
    .Err     (Err),
    .C_valid (C_valid),
    .C_addr  (C_addr),
    .C_data  (C_data),
    .C_rdy   (C_rdy),
    .Busy    (Busy)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int a, input int e, input int b);
    check({tag, ".C_valid"}, 32'(C_valid), v);
    check({tag, ".Ack"},     32'(Ack),     a);
    check({tag, ".Err"},     32'(Err),     e);
    check({tag, ".Busy"},    32'(Busy),    b);
  endtask

  task automatic chk_bus(input string tag, input int a, input int d);
    check({tag, ".C_addr"}, 32'(C_addr), a);
    check({tag, ".C_data"}, 32'(C_data), d);
  endtask

  task automatic set_req(input int i, input logic [CW-1:0] a, input logic [CW-1:0] d);
    Req_addr[i*CW +: CW] = a;
    Req_data[i*CW +: CW] = d;
  endtask

  logic [CW-1:0] rr_addr [NR];
  logic [CW-1:0] rr_data [NR];

  initial begin
    Rst      = 1'b1;
    Req      = '0;
    Req_addr = '0;
    Req_data = '0;
    C_rdy    = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0);
    chk_bus("reset", 0, 0);
    Rst = 1'b0;

    // Stray load acknowledge while idle (VGA_Control's post-reset pulse).
    C_rdy = 1'b1;
    step();
    chk_out("stray_rdy", 0, 0, 0, 0);
    C_rdy = 1'b0;
    step();
    chk_out("stray_rdy_after", 0, 0, 0, 0);

    // Single VGA mode write from requester 0, C_rdy one cycle after C_valid.
    set_req(0, 8'h00, 8'h01);
    Req = 3'b001;
    step();
    chk_out("vga_c1", 1, 0, 0, 1);
    chk_bus("vga_c1", 8'h00, 8'h01);
    step();
    chk_out("vga_c2", 0, 0, 0, 1);
    C_rdy = 1'b1;
    step();
    C_rdy = 1'b0;
    Req   = '0;
    chk_out("vga_c3", 0, 1, 0, 1);
    step();
    chk_out("vga_c4", 0, 0, 0, 0);
    // ptr = 1

    // Illegal mode: Err in cycle 1, bus untouched, ptr advances to 1.
    set_req(0, 8'h00, 8'h03);
    Req = 3'b001;
    step();
    chk_out("illegal_c1", 0, 0, 1, 1);
    chk_bus("illegal_hold", 8'h00, 8'h01);
    Req = '0;
    step();
    chk_out("illegal_c2", 0, 0, 0, 0);

    // Req=101 with ptr=1: requester 2 first, then requester 0.
    set_req(2, 8'h05, 8'hAA);
    set_req(0, 8'h07, 8'h55);
    Req = 3'b101;
    step();
    chk_out("rr101_c1", 1, 0, 0, 1);
    chk_bus("rr101_c1", 8'h05, 8'hAA);
    step();
    chk_out("rr101_c2", 0, 4, 0, 1);
    chk_bus("rr101_hold", 8'h05, 8'hAA);
    Req = 3'b001;
    step();
    chk_out("rr101_c3", 0, 0, 0, 0);
    step();
    chk_out("rr101_c4", 1, 0, 0, 1);
    chk_bus("rr101_c4", 8'h07, 8'h55);
    step();
    chk_out("rr101_c5", 0, 1, 0, 1);
    Req = '0;
    step();
    chk_out("rr101_c6", 0, 0, 0, 0);
    // ptr = 1

    // Timeout: C_rdy never arrives, Err in cycle 2+TO.
    set_req(1, 8'h00, 8'h02);
    Req = 3'b010;
    step();
    chk_out("to_c1", 1, 0, 0, 1);
    chk_bus("to_c1", 8'h00, 8'h02);
    for (int k = 2; k <= TO + 1; k++) begin
      step();
      chk_out("to_wait", 0, 0, 0, 1);
    end
    step();
    chk_out("to_err", 0, 0, 2, 1);
    Req = '0;
    step();
    chk_out("to_after", 0, 0, 0, 0);
    // ptr = 2

    // Reset while in WAIT aborts the write and clears ptr.
    set_req(2, 8'h00, 8'h01);
    Req = 3'b100;
    step();
    chk_out("rstw_c1", 1, 0, 0, 1);
    step();
    chk_out("rstw_c2", 0, 0, 0, 1);
    Rst = 1'b1;
    Req = '0;
    step();
    chk_out("rstw_reset", 0, 0, 0, 0);
    chk_bus("rstw_reset", 0, 0);
    Rst = 1'b0;
    step();
    chk_out("rstw_quiet", 0, 0, 0, 0);

    // Non-VGA write after reset; ptr=0 makes requester 1 win over 2.
    set_req(1, 8'h05, 8'hAA);
    set_req(2, 8'h09, 8'h99);
    Req = 3'b110;
    step();
    chk_out("nonvga_c1", 1, 0, 0, 1);
    chk_bus("nonvga_c1", 8'h05, 8'hAA);
    step();
    chk_out("nonvga_c2", 0, 2, 0, 1);
    Req = '0;
    step();
    chk_out("nonvga_c3", 0, 0, 0, 0);
    // ptr = 2

    // C_rdy on the final WAIT cycle: success wins over timeout.
    set_req(2, 8'h00, 8'h00);
    Req = 3'b100;
    step();
    chk_out("late_c1", 1, 0, 0, 1);
    chk_bus("late_c1", 8'h00, 8'h00);
    for (int k = 2; k <= TO + 1; k++) begin
      step();
      chk_out("late_wait", 0, 0, 0, 1);
    end
    C_rdy = 1'b1;
    step();
    C_rdy = 1'b0;
    chk_out("late_ack", 0, 4, 0, 1);
    Req = '0;
    step();
    chk_out("late_after", 0, 0, 0, 0);
    // ptr = 0

    // Req=111 held, each requester dropping after its Ack: order 0,1,2.
    rr_addr = '{8'h10, 8'h11, 8'h12};
    rr_data = '{8'hA0, 8'hB1, 8'hC2};
    for (int r = 0; r < NR; r++) set_req(r, rr_addr[r], rr_data[r]);
    Req = 3'b111;
    for (int r = 0; r < NR; r++) begin
      step();
      chk_out("rr111_issue", 1, 0, 0, 1);
      chk_bus("rr111_issue", rr_addr[r], rr_data[r]);
      step();
      chk_out("rr111_ack", 0, 1 << r, 0, 1);
      Req[r[1:0]] = 1'b0;
      step();
      chk_out("rr111_idle", 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_cfg_arbiter.md
# vga_cfg_arbiter

Round-robin arbiter and sequencer for the VGA configuration bus. It sits between several configuration masters (mode-select logic, debug/UART bridge, power-on loader) and the VGA_Control configuration port (C_valid/C_addr/C_data/C_rdy). It serialises their writes, issues each write as a single-cycle valid and waits for the resolution-load acknowledge. Each requester gets a one-cycle Ack on success or a one-cycle Err on an illegal mode or a timeout.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- CONFIG_WIDTH, 8: width of config address and data.
- ADDR_VGA_CONFIG, 0: address of the resolution-select register.
- MODE_MAX, 2: highest legal mode code (00=640x480, 01=800x600, 10=1024x768).
- TIMEOUT, 15: WAIT cycles without C_rdy before Err (1..255).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  reset; one clock; reset is synchronous and active-high.
- Req  in  NUM_REQ  per-requester write request; held until that requester's Ack/Err.
- Req_addr  in  NUM_REQ*CONFIG_WIDTH  requester i address at [i*CONFIG_WIDTH +: CONFIG_WIDTH].
- Req_data  in  NUM_REQ*CONFIG_WIDTH  requester i data, same slicing.
- Ack  out  NUM_REQ  one-hot one-cycle success pulse.
- Err  out  NUM_REQ  one-hot one-cycle failure pulse.
- C_valid  out  1  config write strobe to VGA_Control.
- C_addr  out  CONFIG_WIDTH  config address.
- C_data  out  CONFIG_WIDTH  config data.
- C_rdy  in  1  load acknowledge from VGA_Control.
- Busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registered grant index g, round-robin pointer ptr, latched addr/data, timeout counter cnt of width clog2(TIMEOUT+1).
- IDLE:
  - If any Req bit is set, grant the first set bit scanning ptr, ptr+1, … modulo NUM_REQ.
  - Latch g, Req_addr[g] and Req_data[g].
  - If latched addr == ADDR_VGA_CONFIG and data > MODE_MAX, go to RESP with err=1 and do not drive C_valid.
  - Otherwise go to ISSUE.
- ISSUE:
  - C_valid=1 for exactly this cycle; C_addr/C_data take the latched values.
  - If addr == ADDR_VGA_CONFIG, go to WAIT with cnt=0.
  - Otherwise go to RESP with err=0; no acknowledge is expected for other registers.
- WAIT:
  - C_rdy=1: go to RESP with err=0.
  - Otherwise increment cnt; when cnt reaches TIMEOUT, go to RESP with err=1.
  - If C_rdy and timeout coincide, success wins.
- RESP:
  - Pulse Ack[g] (err=0) or Err[g] (err=1) for one cycle.
  - ptr <= (g+1) mod NUM_REQ.
  - Go to IDLE.
- C_rdy is ignored outside WAIT. This includes the Load pulse VGA_Control asserts right after its own reset.
- Req is sampled only in IDLE. If Req[g] drops mid-transaction, the transaction still completes and the Ack/Err pulse is still emitted.
- Changes to Req_addr/Req_data after the grant have no effect.
- C_addr/C_data hold their last values when C_valid=0. Their reset value is 0.
- Ack and Err are never both set. At most one bit of either is set at a time.

## Timing
- Reset: state=IDLE, ptr=0, g=0, cnt=0, err=0.
- Reset values of all outputs: C_valid=0, C_addr=0, C_data=0, Ack=0, Err=0, Busy=0.
- Rst asserted mid-transaction aborts it: no Ack/Err is emitted, and outputs take reset values from the next cycle.
- Latency, counted from Req sampled in IDLE at cycle 0:
  - VGA mode write: C_valid in cycle 1. With VGA_Control, C_rdy arrives in cycle 2, so Ack is in cycle 3.
  - Non-VGA address: C_valid in cycle 1, Ack in cycle 2.
  - Illegal mode: Err in cycle 1, with no C_valid.
  - Timeout: Err in cycle 2+TIMEOUT.
- Back-to-back: the next grant is made in the IDLE cycle after RESP. Minimum spacing between C_valid pulses is 3 cycles (ISSUE-RESP-IDLE-ISSUE for non-VGA writes).
- Requesters must deassert Req in the cycle after seeing Ack/Err.

## Test plan
- Single VGA write: Req=001, addr=0, data=01, C_rdy modelled 1 cycle after C_valid -> C_valid in cycle 1 with C_addr=0, C_data=01; Ack=001 in cycle 3; Busy high in cycles 1-3.
- Round robin: Req=111 held, each requester dropping Req after its Ack -> grant order 0,1,2. With Req=101 and ptr=1 -> requester 2 wins first.
- Illegal mode: addr=0, data=03 -> Err=001 in cycle 1, C_valid never asserted, ptr advances to 1.
- Timeout: TIMEOUT=4, C_rdy held 0 -> Err in cycle 6. Repeat with C_rdy=1 in the final WAIT cycle -> Ack, no Err.
- Non-VGA address: addr=5, data=AA -> single C_valid with C_data=AA, Ack in cycle 2. A stray C_rdy in IDLE (post-reset pulse) produces no Ack/Err.
- Reset in WAIT: assert Rst for one cycle -> C_valid=0, Busy=0, no Ack/Err. Next Req with ptr=0 is granted normally.
